// File: rtl/reg_map_shadow_pkg.sv
// Shared constants and address helpers for the double-buffered
// equalizer register map.
package reg_map_pkg;

   localparam int ADDR_CONFIG      = 0;
   localparam int CTRL_COMMIT_BIT  = 0;
   localparam int STAT_PENDING_BIT = 0;
   localparam int STAT_ERR_BIT     = 1;

   function automatic int bpg(input int w);
      return (w + 7) / 8;
   endfunction

   function automatic int ctrl_addr(input int nb, input int bp);
      return nb * bp + 1;
   endfunction

   function automatic int stat_addr(input int nb, input int bp);
      return nb * bp + 2;
   endfunction

endpackage

// File: rtl/gain_shadow_slot.sv
// One band: byte-lane shadow, dirty flag and active gain register.
// The active copy only moves on a commit while the band is dirty.
module gain_shadow_slot #(
   parameter int GAIN_WIDTH = 24,
   parameter int BPG        = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en_i,
   input  logic [1:0]            wr_lane_i,
   input  logic [7:0]            wr_data_i,
   input  logic                  commit_i,
   input  logic [1:0]            rd_lane_i,
   output logic [7:0]            rd_byte_o,
   output logic                  dirty_o,
   output logic [GAIN_WIDTH-1:0] active_o
);

   localparam int SW = BPG * 8;
   localparam logic [SW-1:0] MASK = {SW{1'b1}} >> (SW - GAIN_WIDTH);

   logic [SW-1:0]         shadow_q, shadow_d;
   logic                  dirty_q;
   logic [GAIN_WIDTH-1:0] active_q;

   // Bits above GAIN_WIDTH are never stored, so they read back as 0.
   always_comb begin
      shadow_d = shadow_q;
      if (wr_en_i) begin
         for (int k = 0; k < BPG; k++) begin
            if (wr_lane_i == 2'(k)) shadow_d[k*8 +: 8] = wr_data_i;
         end
      end
      shadow_d = shadow_d & MASK;
   end

   always_comb begin
      rd_byte_o = '0;
      for (int k = 0; k < BPG; k++) begin
         if (rd_lane_i == 2'(k)) rd_byte_o = shadow_q[k*8 +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_q <= '0;
         dirty_q  <= 1'b0;
         active_q <= '0;
      end else begin
         shadow_q <= shadow_d;
         if (wr_en_i)       dirty_q <= 1'b1;
         else if (commit_i) dirty_q <= 1'b0;
         if (commit_i && dirty_q) active_q <= shadow_q[GAIN_WIDTH-1:0];
      end
   end

   assign dirty_o  = dirty_q;
   assign active_o = active_q;

endmodule

// File: rtl/reg_map_shadow.sv
// Host byte register map with shadowed gains committed on sample_tick,
// plus CONFIG, CTRL, STATUS and registered readback.
module reg_map_shadow
   import reg_map_pkg::*;
#(
   parameter int NUM_BANDS   = 10,
   parameter int GAIN_WIDTH  = 24,
   parameter int ADDR_WIDTH  = 8,
   parameter int AUTO_COMMIT = 0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            we,
   input  logic                            re,
   input  logic [ADDR_WIDTH-1:0]           addr,
   input  logic [7:0]                      data_in,
   output logic [7:0]                      data_out,
   output logic                            rd_valid,
   input  logic                            sample_tick,
   output logic [7:0]                      configuration,
   output logic [NUM_BANDS*GAIN_WIDTH-1:0] gains,
   output logic                            gain_update,
   output logic                            commit_pending
);

   localparam int BPG    = bpg(GAIN_WIDTH);
   localparam int CTRL_A = ctrl_addr(NUM_BANDS, BPG);
   localparam int STAT_A = stat_addr(NUM_BANDS, BPG);

   logic [NUM_BANDS-1:0] hit, top_wr, dirty;
   logic [1:0]           lane    [NUM_BANDS];
   logic [7:0]           rd_byte [NUM_BANDS];

   logic       is_cfg, is_ctrl, is_stat, mapped, commit, auto_req;
   logic [7:0] cfg_q, cfg_d;
   logic       pending_q, pending_d;
   logic       err_q, err_d;
   logic [7:0] dout_q, dout_d, stat;
   logic       rdv_q;
   logic       gupd_q, gupd_d;

   assign commit = sample_tick & pending_q;

   for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
      localparam int BASE = 1 + b * BPG;
      logic [ADDR_WIDTH-1:0] off;

      // Wraps for addresses below BASE, so the range test stays unsigned.
      assign off       = addr - ADDR_WIDTH'(BASE);
      assign hit[b]    = off < ADDR_WIDTH'(BPG);
      assign lane[b]   = 2'(off);
      assign top_wr[b] = we & hit[b] & (lane[b] == 2'(BPG - 1));

      gain_shadow_slot #(
         .GAIN_WIDTH (GAIN_WIDTH),
         .BPG        (BPG)
      ) u_slot (
         .clk       (clk),
         .rst       (rst),
         .wr_en_i   (we & hit[b]),
         .wr_lane_i (lane[b]),
         .wr_data_i (data_in),
         .commit_i  (commit),
         .rd_lane_i (lane[b]),
         .rd_byte_o (rd_byte[b]),
         .dirty_o   (dirty[b]),
         .active_o  (gains[b*GAIN_WIDTH +: GAIN_WIDTH])
      );
   end

   assign is_cfg   = addr == ADDR_WIDTH'(ADDR_CONFIG);
   assign is_ctrl  = addr == ADDR_WIDTH'(CTRL_A);
   assign is_stat  = addr == ADDR_WIDTH'(STAT_A);
   assign mapped   = is_cfg | is_ctrl | is_stat | (|hit);
   assign auto_req = (AUTO_COMMIT != 0) && (|top_wr);

   always_comb begin
      cfg_d     = cfg_q;
      pending_d = pending_q;
      err_d     = err_q;
      if (we && is_cfg) cfg_d = data_in;
      // A request landing on a committing tick survives for the next one.
      if (commit) pending_d = 1'b0;
      if ((we && is_ctrl && data_in[CTRL_COMMIT_BIT]) || auto_req)
         pending_d = 1'b1;
      if (we && is_stat && data_in[STAT_ERR_BIT]) err_d = 1'b0;
      if (we && !mapped) err_d = 1'b1;
   end

   always_comb begin
      stat                   = '0;
      stat[STAT_PENDING_BIT] = pending_q;
      stat[STAT_ERR_BIT]     = err_q;
      dout_d                 = dout_q;
      if (re) begin
         unique case (1'b1)
            is_cfg:  dout_d = cfg_q;
            is_stat: dout_d = stat;
            |hit: begin
               dout_d = '0;
               for (int b = 0; b < NUM_BANDS; b++) begin
                  if (hit[b]) dout_d = rd_byte[b];
               end
            end
            default: dout_d = '0;
         endcase
      end
   end

   assign gupd_d = commit & (|dirty);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_q     <= '0;
         pending_q <= 1'b0;
         err_q     <= 1'b0;
         dout_q    <= '0;
         rdv_q     <= 1'b0;
         gupd_q    <= 1'b0;
      end else begin
         cfg_q     <= cfg_d;
         pending_q <= pending_d;
         err_q     <= err_d;
         dout_q    <= dout_d;
         rdv_q     <= re;
         gupd_q    <= gupd_d;
      end
   end

   assign data_out       = dout_q;
   assign rd_valid       = rdv_q;
   assign configuration  = cfg_q;
   assign gain_update    = gupd_q;
   assign commit_pending = pending_q;

endmodule

// File: tb/tb_reg_map_shadow.sv
// Scoreboard bench for reg_map_shadow: default map plus an
// auto-commit, 20-bit-gain instance sharing the bus.
module tb_reg_map_shadow;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       we = 1'b0, we2 = 1'b0, re = 1'b0, sample_tick = 1'b0;
   logic [7:0] addr = '0, data_in = '0;

   logic [7:0]   data_out, configuration, data_out2, configuration2;
   logic         rd_valid, gain_update, commit_pending;
   logic         rd_valid2, gain_update2, commit_pending2;
   logic [239:0] gains;
   logic [199:0] gains2;

   logic [7:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   reg_map_shadow dut (
      .clk            (clk),
      .rst            (rst),
      .we             (we),
      .re             (re),
      .addr           (addr),
      .data_in        (data_in),
      .data_out       (data_out),
      .rd_valid       (rd_valid),
      .sample_tick    (sample_tick),
      .configuration  (configuration),
      .gains          (gains),
      .gain_update    (gain_update),
      .commit_pending (commit_pending)
   );

   reg_map_shadow #(
      .GAIN_WIDTH  (20),
      .AUTO_COMMIT (1)
   ) dut2 (
      .clk            (clk),
      .rst            (rst),
      .we             (we2),
      .re             (re),
      .addr           (addr),
      .data_in        (data_in),
      .data_out       (data_out2),
      .rd_valid       (rd_valid2),
      .sample_tick    (sample_tick),
      .configuration  (configuration2),
      .gains          (gains2),
      .gain_update    (gain_update2),
      .commit_pending (commit_pending2)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rd_valid) begin
         if (exp_q.size() == 0) chk("rd_unexpected", 32'(exp_q.size()), 1);
         else chk("rd_data", 32'(data_out), 32'(exp_q.pop_front()));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      addr = a; data_in = d; we = 1'b1;
      cyc();
      we = 1'b0;
   endtask

   task automatic wr2(input logic [7:0] a, input logic [7:0] d);
      addr = a; data_in = d; we2 = 1'b1;
      cyc();
      we2 = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] e);
      addr = a; re = 1'b1;
      exp_q.push_back(e);
      cyc();
      re = 1'b0;
   endtask

   task automatic tick();
      sample_tick = 1'b1;
      cyc();
      sample_tick = 1'b0;
   endtask

   initial begin
      logic [23:0] v;
      #1;
      chk("rst_gains", 32'(|gains), 0);
      chk("rst_cfg", 32'(configuration), 0);
      chk("rst_pend", 32'(commit_pending), 0);
      chk("rst_rdv", 32'(rd_valid), 0);
      cyc();
      rst = 1'b1;
      cyc();

      // auto-commit, 20-bit instance
      wr2(8'h01, 8'hFF);
      wr2(8'h02, 8'hFF);
      chk("auto_pend2", 32'(commit_pending2), 0);
      wr2(8'h03, 8'hFF);
      chk("auto_pend3", 32'(commit_pending2), 1);
      tick();
      chk("auto_gain", 32'(gains2[19:0]), 32'h000F_FFFF);
      chk("auto_gupd", 32'(gain_update2), 1);
      chk("auto_pclr", 32'(commit_pending2), 0);
      rd(8'h03, 8'h00);
      chk("auto_rb", 32'(data_out2), 32'h0F);

      // reset in the middle of a write burst
      wr(8'h00, 8'h5A);
      wr(8'h01, 8'h11); wr(8'h02, 8'h22); wr(8'h03, 8'h33);
      wr(8'h1F, 8'h01);
      tick();
      chk("pre_gain", 32'(gains[23:0]), 32'h332211);
      chk("pre_cfg", 32'(configuration), 32'h5A);
      wr(8'h1F, 8'h01);
      wr(8'h04, 8'hAA);
      addr = 8'h05; data_in = 8'hBB; we = 1'b1;
      #2 rst = 1'b0;
      #1;
      chk("mid_gains", 32'(|gains), 0);
      chk("mid_cfg", 32'(configuration), 0);
      chk("mid_pend", 32'(commit_pending), 0);
      we = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      rd(8'h20, 8'h00);
      rd(8'h04, 8'h00);

      // shadow then commit, band 2
      wr(8'h04, 8'hC7); wr(8'h05, 8'h71); wr(8'h06, 8'h1C);
      chk("shadow_hold", 32'(gains[47:24]), 0);
      rd(8'h04, 8'hC7); rd(8'h05, 8'h71); rd(8'h06, 8'h1C);
      wr(8'h1F, 8'h01);
      chk("ctrl_pend", 32'(commit_pending), 1);
      tick();
      chk("b2_gain", 32'(gains[47:24]), 32'h1C71C7);
      chk("b2_gupd", 32'(gain_update), 1);
      cyc();
      chk("b2_gupd_off", 32'(gain_update), 0);
      rd(8'h20, 8'h00);
      rd(8'h1F, 8'h00);

      // load all bands
      for (int b = 0; b < 10; b++) begin
         v = 24'(b * 32'h1C71C7);
         for (int k = 0; k < 3; k++) wr(8'(1 + b*3 + k), 8'(v >> (8*k)));
      end
      wr(8'h1F, 8'h01);
      tick();
      for (int b = 0; b < 10; b++)
         chk($sformatf("band%0d", b + 1), 32'(gains[b*24 +: 24]),
             32'(24'(b * 32'h1C71C7)));

      // CTRL write on the tick is deferred
      wr(8'h01, 8'h55);
      addr = 8'h1F; data_in = 8'h01; we = 1'b1; sample_tick = 1'b1;
      cyc();
      we = 1'b0; sample_tick = 1'b0;
      chk("defer_gain", 32'(gains[23:0]), 0);
      chk("defer_pend", 32'(commit_pending), 1);
      chk("defer_gupd", 32'(gain_update), 0);
      tick();
      chk("defer_commit", 32'(gains[23:0]), 32'h000055);

      // byte write on a committing tick
      wr(8'h02, 8'h66);
      wr(8'h1F, 8'h01);
      addr = 8'h02; data_in = 8'h77; we = 1'b1; sample_tick = 1'b1;
      cyc();
      we = 1'b0; sample_tick = 1'b0;
      chk("race_old", 32'(gains[23:0]), 32'h006655);
      chk("race_pclr", 32'(commit_pending), 0);
      wr(8'h1F, 8'h01);
      tick();
      chk("race_new", 32'(gains[23:0]), 32'h007755);
      chk("race_gupd", 32'(gain_update), 1);
      rd(8'h02, 8'h77);

      // error flag and read semantics
      rd(8'h40, 8'h00);
      rd(8'h20, 8'h00);
      wr(8'h40, 8'h99);
      rd(8'h20, 8'h02);
      wr(8'h20, 8'h02);
      rd(8'h20, 8'h00);
      addr = 8'h04; data_in = 8'hEE; we = 1'b1; re = 1'b1;
      exp_q.push_back(8'hC7);
      cyc();
      we = 1'b0; re = 1'b0;
      rd(8'h04, 8'hEE);

      repeat (3) cyc();
      chk("rd_drain", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reg_map_shadow.md
# reg_map_shadow

Parametrised, double-buffered successor to the equalizer's configuration register map. It collects byte-wide host writes into shadow registers and holds them there. Shadowed gains reach the active outputs only on a commit that is aligned to the audio `sample_tick`, so a filter bank never sees a half-written gain. It also adds registered readback, a status register, and an optional per-band auto-commit mode. It sits between the host byte interface (SPI/I2C bridge) and the equalizer datapath.

## Interface
- `NUM_BANDS`, 10, number of gain bands
- `GAIN_WIDTH`, 24, bits per gain (1..32)
- `ADDR_WIDTH`, 8, byte-address width; `NUM_BANDS*BPG+3 <= 2**ADDR_WIDTH` is required, with `BPG = ceil(GAIN_WIDTH/8)`
- `AUTO_COMMIT`, 0, when 1, writing a band's most-significant byte requests a commit automatically
- `clk` in 1: system clock
- `rst` in 1: asynchronous, active-low reset
- `we` in 1: write strobe, one byte per cycle
- `re` in 1: read strobe
- `addr` in `ADDR_WIDTH`: byte address
- `data_in` in 8: write data
- `data_out` out 8: read data, registered
- `rd_valid` out 1: `data_out` valid pulse
- `sample_tick` in 1: one-cycle audio-sample strobe; this is the commit point
- `configuration` out 8: active configuration byte
- `gains` out `NUM_BANDS*GAIN_WIDTH`: active gains; band b occupies `[b*GAIN_WIDTH +: GAIN_WIDTH]`, band 0 (external "band 1") at the LSBs
- `gain_update` out 1: one-cycle pulse in the cycle after the active gains change
- `commit_pending` out 1: a commit is waiting for `sample_tick`

## Operation
- **Address map:**
  - 0x00 CONFIG.
  - `1+b*BPG+k` is byte k (little-endian, k=0 is LSB) of band b's shadow.
  - CTRL is at `NUM_BANDS*BPG+1`.
  - STATUS is at CTRL+1.
  - Defaults: CTRL=0x1F, STATUS=0x20.
- **CONFIG:** written directly to the active register; it is not shadowed.
- **Band byte write:** updates the shadow byte and sets `dirty[b]`. Bits of the top byte at or above `GAIN_WIDTH` are discarded and read back as 0.
- **CTRL write, bit0=1:** sets `pending`. The other bits are ignored. CTRL reads as 0x00.
- **AUTO_COMMIT=1:** a write to byte `BPG-1` of any band also sets `pending`.
- **Commit:** on a cycle with `sample_tick=1` and registered `pending=1`:
  - every band with `dirty[b]=1` copies shadow to active;
  - `dirty` and `pending` are cleared;
  - `gain_update` pulses in the next cycle only if at least one band was dirty.
- **Commit with no dirty bands:** clears `pending` and produces no pulse.
- **STATUS read:** bit0 = `pending`, bit1 = `err`, other bits 0.
- **`err`:** sticky; set by any write to an unmapped address, which is otherwise ignored. Writing STATUS with bit1=1 clears it.
- **Reads:**
  - band addresses return the shadow byte;
  - CONFIG returns the active value;
  - unmapped addresses return 0x00 and do not set `err`.
- **Reset values (asynchronous, `rst`=0):** all of the following are 0: `configuration`, shadows, `gains`, `dirty`, `pending`, `err`, `data_out`, `rd_valid`, `gain_update`.

## Timing
- **Writes:** take effect at the rising edge where `we`=1. Readback is visible to a read issued one cycle later.
- **Reads:** `re` at edge N gives `data_out`/`rd_valid` valid after edge N (one-cycle latency). `rd_valid` is high for exactly one cycle.
- **`we` and `re` in the same cycle to the same address:** the read returns the pre-write value.
- **Commit request and `sample_tick` in the same cycle:** the tick sees the old `pending`=0, so the commit is deferred to the next tick.
- **Band byte write in the same cycle as a committing tick:** active gets the pre-write shadow. `dirty[b]` stays set, because the set has priority over the clear.
- **Commit latency:** `gains` change on the tick edge; `gain_update` is high the following cycle.
- **`commit_pending`:** equals `pending`.
- **Reset mid-sequence:** all state is lost immediately, including partially written shadows and any pending commit.

## Structure
- **Shared package `reg_map_pkg`:**
  - `BPG` function (`ceil(w/8)`);
  - `ADDR_CONFIG`, the CTRL/STATUS address functions of `NUM_BANDS` and `BPG`;
  - `CTRL_COMMIT_BIT`, `STAT_PENDING_BIT`, `STAT_ERR_BIT`.
- **Sub-module `gain_shadow_slot`:** one per band, generated `NUM_BANDS` times. It holds the byte-lane shadow, dirty flag and active register, and has ports for byte write, commit, shadow readback byte-select and active output.
- **Top level:** address decode, CTRL/STATUS, the read mux and the `gain_update` register.

## Test plan
- **Reset:** drive `rst`=0 mid-write burst -> `gains`=0, `configuration`=0, `commit_pending`=0. After release, STATUS reads 0x00.
- **Default parameters, shadow then commit:**
  - write band 2 bytes C7,71,1C -> `gains[47:24]` stays 0 and the readback of 0x04..0x06 returns C7,71,1C;
  - write CTRL=0x01 -> `commit_pending`=1;
  - `sample_tick` -> `gains[47:24]`=0x1C71C7, `gain_update` pulses once, and STATUS reads 0x00.
- **Load all bands:** program bands 1..10 with 0x000000, 0x1C71C7 … 0xFFFFFF, then CTRL=0x01 and a tick -> all ten active values match.
- **Simultaneous events:**
  - CTRL write in the same cycle as `sample_tick` -> no change; the next tick commits;
  - a byte write on a committing tick -> the old byte is committed and `dirty` remains set, shown by a second commit that applies the new byte.
- **`AUTO_COMMIT`=1, `GAIN_WIDTH`=20:** write band 1 bytes FF,FF,FF -> `pending` sets on the third byte; after a tick the active value is 0xFFFFF and the top-byte readback is 0x0F.
- **Error and read semantics:**
  - write to 0x40 -> STATUS=0x02, and a STATUS write of 0x02 clears it;
  - `re` and `we` in the same cycle -> the old value is returned with `rd_valid` one cycle later.
